// File: rtl/i2c_pkg.sv
// Shared SCCB/I2C definitions: responder state encoding, default device
// address and the bus-level ACK/NACK and read/write bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV      = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_SUB      = 4'd3,
    ST_SUB_ACK  = 4'd4,
    ST_WDAT     = 4'd5,
    ST_WDAT_ACK = 4'd6,
    ST_RDAT     = 4'd7,
    ST_RDAT_ACK = 4'd8
  } sccb_state_e;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h21;

  // Level seen on SDA during the 9th bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic I2C_RW_READ = 1'b1;

  function automatic logic id_matches(input logic [7:0] id_byte,
                                      input logic [6:0] dev_addr);
    return id_byte[7:1] == dev_addr;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Brings SCL/SDA into the clk domain and turns them into single-cycle
// SCL-edge, START and STOP pulses plus the SDA level sampled alongside them.
module sccb_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  localparam int SCL = 0;
  localparam int SDA = 1;

  logic [1:0] pin_w;
  logic [1:0] cur_w;
  logic [1:0] prev_w;

  assign pin_w = {sda_i, scl_i};

  // Two synchronizer stages and one history stage per line, all idling high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= 1'b1;
        sync_q <= 1'b1;
        hist_q <= 1'b1;
      end else begin
        meta_q <= pin_w[gi];
        sync_q <= meta_q;
        hist_q <= sync_q;
      end
    end

    assign cur_w[gi]  = sync_q;
    assign prev_w[gi] = hist_q;
  end

  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;
  logic scl_high_w;

  assign scl_high_w = cur_w[SCL] & prev_w[SCL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_rise_q <= cur_w[SCL] & ~prev_w[SCL];
      scl_fall_q <= ~cur_w[SCL] & prev_w[SCL];
      start_q    <= scl_high_w & prev_w[SDA] & ~cur_w[SDA];
      stop_q     <= scl_high_w & ~prev_w[SDA] & cur_w[SDA];
      sda_q      <= cur_w[SDA];
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_sccb_slave.sv
// SCCB/I2C responder backed by a 256x8 register bank: accepts 3-phase writes,
// answers 2-phase reads, and exposes every accepted byte as a write strobe.
module i2c_sccb_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
  parameter bit         ACK_ON_DATA = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;

  sccb_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_s)
  );

  sccb_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0]  bank_w [256];
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic        ack_bit;

  // Bank entries are written the cycle wr_en is high and clear on reset.
  for (genvar gi = 0; gi < 256; gi++) begin : g_bank
    logic [7:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q <= 8'h00;
      end else if (wr_en_q && (wr_addr_q == 8'(gi))) begin
        mem_q <= wr_data_q;
      end
    end

    assign bank_w[gi] = mem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // In ACK slots bit_cnt marks progress: 0 = awaiting 8th fall, 1 = slot open,
  // 2 (reads only) = master bit sampled, awaiting 9th fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rx_byte   = {shift_q[6:0], sda_s};
    rd_byte   = bank_w[ptr_q];
    ack_bit   = I2C_ACK;

    if (bus_stop) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (bus_start) begin
      state_d   = ST_DEV;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_DEV, ST_SUB, ST_WDAT: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              if (state_q == ST_DEV) begin
                if (id_matches(rx_byte, DEV_ADDR)) begin
                  rw_d    = rx_byte[0];
                  state_d = ST_DEV_ACK;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_SUB) begin
                ptr_d   = rx_byte;
                state_d = ST_SUB_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + 8'd1;
                state_d   = ST_WDAT_ACK;
              end
            end
          end
        end

        ST_DEV_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
          if ((state_q == ST_WDAT_ACK) && !ACK_ON_DATA) begin
            ack_bit = I2C_NACK;
          end
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd1;
              sda_oe_d  = (ack_bit == I2C_ACK);
            end else begin
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
              if ((state_q == ST_DEV_ACK) && (rw_q == I2C_RW_READ)) begin
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
                state_d  = ST_RDAT;
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_SUB;
              end else begin
                state_d = ST_WDAT;
              end
            end
          end
        end

        ST_RDAT: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = ST_RDAT_ACK;
            end
          end else if (scl_fall && (bit_cnt_q != 3'd0)) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end

        ST_RDAT_ACK: begin
          if (scl_fall && (bit_cnt_q == 3'd0)) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd1;
          end else if (scl_rise && (bit_cnt_q == 3'd1)) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_s == I2C_NACK) begin
              bit_cnt_d = 3'd0;
              state_d   = ST_IDLE;
            end else begin
              bit_cnt_d = 3'd2;
            end
          end else if (scl_fall && (bit_cnt_q == 3'd2)) begin
            // ptr_q already points at the next byte here.
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RDAT;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign dbg_data = bank_w[dbg_addr];

endmodule
